// File: rtl/atf_cfg_pkg.sv
// Shared definitions for the macrocell configuration loader:
// word geometry, field positions, FSM encoding and the parity rule.
package atf_cfg_pkg;

    localparam int CW = 15;
    localparam int FW = CW + 1;

    localparam int XOR_A_MUX_BIT    = 0;
    localparam int XOR_B_MUX_BIT    = 1;
    localparam int XOR_INV_MUX_BIT  = 2;
    localparam int O_MUX_BIT        = 3;
    localparam int D_MUX_BIT        = 4;
    localparam int PT4_MUX_BIT      = 5;
    localparam int PT4_FUNC_MUX_BIT = 6;
    localparam int PT5_FUNC_MUX_BIT = 7;
    localparam int STORAGE_MUX_BIT  = 8;
    localparam int OE_MUX_LSB       = 9;
    localparam int OE_MUX_W         = 3;
    localparam int GCLK_MUX_LSB     = 12;
    localparam int GCLK_MUX_W       = 2;
    localparam int GCLR_MUX_BIT     = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA
    } state_t;

    // Parity bit that makes the 16-bit transmitted word carry an odd number of ones.
    function automatic logic odd_parity(input logic [CW-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/cfg_shifter.sv
// 16-bit LSB-first shift register: captures write frames and
// serialises read responses (bit 0 is always the next bit out).
module cfg_shifter
    import atf_cfg_pkg::*;
(
    input  logic          clk,
    input  logic          clrn,
    input  logic          load,
    input  logic          shift,
    input  logic          sin,
    input  logic [FW-1:0] load_val,
    output logic [FW-1:0] q,
    output logic          sout
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {sin, q[FW-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/mc_cfg_loader.sv
// Serial loader/readback for per-macrocell configuration words.
// Frames are LSB first: start, cmd, 4 address bits, then 16 data bits.
module mc_cfg_loader
    import atf_cfg_pkg::*;
#(
    parameter int NMC = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              sen,
    input  logic              sdi,
    input  logic              abort,
    output logic              sdo,
    output logic [NMC*CW-1:0] cfg,
    output logic [NMC-1:0]    cfg_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    addr;
    logic [3:0]    addr_full;
    logic          is_read;
    logic          addr_ok;
    logic [CW-1:0] rd_word;
    logic [FW-1:0] sh_q;
    logic          sh_out;
    logic          sh_load;
    logic          sh_shift;
    logic          wr_en;
    logic          done_next;
    logic          err_next;

    assign addr_full = {sdi, addr[3:1]};
    assign addr_ok   = ({1'b0, addr} < 5'(NMC));
    assign busy      = (state != ST_IDLE);
    assign sdo       = (state == ST_RDATA) & sh_out;

    // Out-of-range addresses match no entry, so they read back as all zeros.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NMC; i++) begin
            if (addr_full == 4'(i)) begin
                rd_word = cfg[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_next = state;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        wr_en      = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else if (sen) begin
            case (state)
                ST_IDLE: begin
                    if (sdi) state_next = ST_CMD;
                end
                ST_CMD: state_next = ST_ADDR;
                ST_ADDR: begin
                    if (cnt == 4'd3) begin
                        state_next = is_read ? ST_RDATA : ST_WDATA;
                        sh_load    = is_read;
                    end
                end
                ST_WDATA: begin
                    sh_shift = 1'b1;
                    if (cnt == 4'd15) begin
                        state_next = ST_IDLE;
                        if (addr_ok && (odd_parity(sh_q[FW-1:1]) == sdi)) begin
                            wr_en     = 1'b1;
                            done_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    sh_shift = 1'b1;
                    if (cnt == 4'd15) begin
                        state_next = ST_IDLE;
                        done_next  = addr_ok;
                        err_next   = !addr_ok;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // The bit counter restarts whenever the FSM changes phase.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr    <= '0;
            is_read <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            err   <= err_next;
            if (abort) begin
                cnt <= '0;
            end else if (sen) begin
                cnt <= (state_next == state && state != ST_IDLE) ? cnt + 4'd1 : 4'd0;
                if (state == ST_CMD)  is_read <= sdi;
                if (state == ST_ADDR) addr    <= addr_full;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cfg       <= '0;
            cfg_valid <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NMC; i++) begin
                if (addr == 4'(i)) begin
                    cfg[i*CW +: CW] <= sh_q[FW-1:1];
                    cfg_valid[i]    <= 1'b1;
                end
            end
        end
    end

    cfg_shifter u_shifter (
        .clk      (clk),
        .clrn     (clrn),
        .load     (sh_load),
        .shift    (sh_shift),
        .sin      ((state == ST_WDATA) ? sdi : 1'b0),
        .load_val ({odd_parity(rd_word), rd_word}),
        .q        (sh_q),
        .sout     (sh_out)
    );

endmodule

// File: tb/tb_mc_cfg_loader.sv
// Directed bench for mc_cfg_loader built with NMC=8 so that address 12
// exercises the out-of-range paths alongside normal writes and reads.
module tb_mc_cfg_loader;

    localparam int NMC = 8;

    logic              clk = 1'b0;
    logic              clrn;
    logic              sen;
    logic              sdi;
    logic              abort;
    logic              sdo;
    logic [NMC*15-1:0] cfg;
    logic [NMC-1:0]    cfg_valid;
    logic              busy;
    logic              done;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;

    logic [NMC*15-1:0] exp_cfg   = '0;
    logic [NMC-1:0]    exp_valid = '0;

    mc_cfg_loader #(.NMC(NMC)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .sen       (sen),
        .sdi       (sdi),
        .abort     (abort),
        .sdo       (sdo),
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic step(input logic s, input logic d, input logic a);
        sen   = s;
        sdi   = d;
        abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic cmd, input logic [3:0] a);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, cmd, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, a[i], 1'b0);
    endtask

    task automatic send_write(input logic [3:0] a, input logic [14:0] w, input logic p);
        send_header(1'b0, a);
        for (int i = 0; i < 15; i++) step(1'b1, w[i], 1'b0);
        step(1'b1, p, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (sdo !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_sdo got %b want 0", sdo); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests_run++; if ({done, err} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_done_err got %b want 00", {done, err}); end
        tests_run++; if (cfg !== '0) begin tests_failed++; $display("[TB] FAIL reset_cfg got %h want 0", cfg); end
        tests_run++; if (cfg_valid !== '0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", cfg_valid); end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_ignore();
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_ignore_busy got %b want 0", busy); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (done_cnt + err_cnt != 0) begin tests_failed++; $display("[TB] FAIL idle_ignore_pulses got %0d want 0", done_cnt + err_cnt); end
    endtask

    task automatic test_bad_parity();
        done_cnt = 0;
        err_cnt  = 0;
        send_write(4'd3, 15'h1234, 1'b1);
        tests_run++; if ({done, err} !== 2'b01) begin tests_failed++; $display("[TB] FAIL badpar_flags got done,err=%b want 01", {done, err}); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL badpar_busy got %b want 0", busy); end
        tests_run++; if (cfg !== exp_cfg) begin tests_failed++; $display("[TB] FAIL badpar_cfg got %h want %h", cfg, exp_cfg); end
        tests_run++; if (cfg_valid[3] !== 1'b0) begin tests_failed++; $display("[TB] FAIL badpar_valid got %b want 0", cfg_valid[3]); end
        tests_run++; if (err_cnt != 1 || done_cnt != 0) begin tests_failed++; $display("[TB] FAIL badpar_pulses got err=%0d done=%0d want 1/0", err_cnt, done_cnt); end
    endtask

    task automatic test_write_good();
        done_cnt = 0;
        err_cnt  = 0;
        send_write(4'd3, 15'h1234, 1'b0);
        exp_cfg[45 +: 15] = 15'h1234;
        exp_valid[3]      = 1'b1;
        tests_run++; if ({done, err} !== 2'b10) begin tests_failed++; $display("[TB] FAIL write_flags got done,err=%b want 10", {done, err}); end
        tests_run++; if (cfg[59:45] !== 15'h1234) begin tests_failed++; $display("[TB] FAIL write_entry3 got %h want 1234", cfg[59:45]); end
        tests_run++; if (cfg_valid !== 8'h08) begin tests_failed++; $display("[TB] FAIL write_valid got %b want 00001000", cfg_valid); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("[TB] FAIL write_after got busy,done=%b want 00", {busy, done}); end
        tests_run++; if (done_cnt != 1 || err_cnt != 0) begin tests_failed++; $display("[TB] FAIL write_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    endtask

    task automatic test_read_toggle();
        logic [15:0] w;
        w        = 16'h1234;
        done_cnt = 0;
        err_cnt  = 0;
        send_header(1'b1, 4'd3);
        tests_run++; if (sdo !== w[0]) begin tests_failed++; $display("[TB] FAIL read_bit0 got %b want %b", sdo, w[0]); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            tests_run++; if (sdo !== w[i]) begin tests_failed++; $display("[TB] FAIL read_hold bit %0d got %b want %b", i, sdo, w[i]); end
            step(1'b1, 1'b0, 1'b0);
            if (i < 15) begin
                tests_run++; if (sdo !== w[i+1]) begin tests_failed++; $display("[TB] FAIL read_shift bit %0d got %b want %b", i + 1, sdo, w[i+1]); end
            end
        end
        tests_run++; if ({done, err, sdo, busy} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL read_end got done,err,sdo,busy=%b want 1000", {done, err, sdo, busy}); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (done_cnt != 1 || err_cnt != 0) begin tests_failed++; $display("[TB] FAIL read_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
    endtask

    task automatic test_abort();
        logic [14:0] wa;
        wa       = 15'h2AAA;
        done_cnt = 0;
        err_cnt  = 0;
        send_header(1'b0, 4'd5);
        for (int i = 0; i < 8; i++) step(1'b1, wa[i], 1'b0);
        step(1'b1, wa[8], 1'b1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (done_cnt + err_cnt != 0) begin tests_failed++; $display("[TB] FAIL abort_pulses got %0d want 0", done_cnt + err_cnt); end
        tests_run++; if (cfg !== exp_cfg || cfg_valid !== exp_valid) begin tests_failed++; $display("[TB] FAIL abort_state got cfg=%h valid=%b want %h/%b", cfg, cfg_valid, exp_cfg, exp_valid); end
        send_write(4'd5, 15'h0155, 1'b0);
        exp_cfg[75 +: 15] = 15'h0155;
        exp_valid[5]      = 1'b1;
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_rewrite_done got %b want 1", done); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (cfg !== exp_cfg) begin tests_failed++; $display("[TB] FAIL abort_rewrite_cfg got %h want %h", cfg, exp_cfg); end
        tests_run++; if (cfg_valid !== 8'h28) begin tests_failed++; $display("[TB] FAIL abort_rewrite_valid got %b want 00101000", cfg_valid); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] w;
        w        = 16'h8000;
        done_cnt = 0;
        err_cnt  = 0;
        send_write(4'd12, 15'h1234, 1'b0);
        tests_run++; if ({done, err} !== 2'b01) begin tests_failed++; $display("[TB] FAIL oor_write_flags got done,err=%b want 01", {done, err}); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (cfg !== exp_cfg || cfg_valid !== exp_valid) begin tests_failed++; $display("[TB] FAIL oor_write_state got cfg=%h valid=%b want %h/%b", cfg, cfg_valid, exp_cfg, exp_valid); end
        send_header(1'b1, 4'd12);
        for (int i = 0; i < 16; i++) begin
            tests_run++; if (sdo !== w[i]) begin tests_failed++; $display("[TB] FAIL oor_read bit %0d got %b want %b", i, sdo, w[i]); end
            step(1'b1, 1'b0, 1'b0);
        end
        tests_run++; if ({done, err, sdo, busy} !== 4'b0100) begin tests_failed++; $display("[TB] FAIL oor_read_end got done,err,sdo,busy=%b want 0100", {done, err, sdo, busy}); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++; if (err_cnt != 2 || done_cnt != 0) begin tests_failed++; $display("[TB] FAIL oor_pulses got err=%0d done=%0d want 2/0", err_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid_read();
        done_cnt = 0;
        send_header(1'b1, 4'd3);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrd_busy_before got %b want 1", busy); end
        #2;
        clrn = 1'b0;
        #1;
        exp_cfg   = '0;
        exp_valid = '0;
        tests_run++; if ({sdo, busy} !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrd_outputs got sdo,busy=%b want 00", {sdo, busy}); end
        tests_run++; if (cfg !== '0 || cfg_valid !== '0) begin tests_failed++; $display("[TB] FAIL midrd_clear got cfg=%h valid=%b want 0/0", cfg, cfg_valid); end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        send_write(4'd0, 15'h7FFF, 1'b0);
        exp_cfg[0 +: 15] = 15'h7FFF;
        exp_valid[0]     = 1'b1;
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrd_rewrite_done got %b want 1", done); end
        tests_run++; if (cfg !== exp_cfg || cfg_valid !== 8'h01) begin tests_failed++; $display("[TB] FAIL midrd_rewrite_state got cfg=%h valid=%b want %h/00000001", cfg, cfg_valid, exp_cfg); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clrn  = 1'b0;
        sen   = 1'b0;
        sdi   = 1'b0;
        abort = 1'b0;
        test_reset();
        test_idle_ignore();
        test_bad_parity();
        test_write_good();
        test_read_toggle();
        test_abort();
        test_out_of_range();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
